// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the 6502 instruction fetch stage: FSM state encodings
// and the default reset vector address.
package cpu_fetch_pkg;

    typedef enum logic [2:0] {
        FETCH_VEC_LO = 3'd0,
        FETCH_VEC_HI = 3'd1,
        FETCH_OPC    = 3'd2,
        FETCH_OP1    = 3'd3,
        FETCH_OP2    = 3'd4,
        FETCH_HOLD   = 3'd5
    } fetch_state_t;

    localparam logic [15:0] DEFAULT_VECTOR_ADDR = 16'hFFFC;

endpackage

// File: rtl/cpu_fetch_ins_length.sv
// Combinational 6502 opcode length decoder: opcode aaa_bbb_cc -> length 1..3
// and an illegal flag for the cc=11 column.
module cpu_ins_length (
    input  logic [7:0] opcode,
    output logic [1:0] len,
    output logic       inval
);

    logic [2:0] bbb;
    logic [1:0] cc;

    assign bbb = opcode[4:2];
    assign cc  = opcode[1:0];

    always_comb begin
        len   = 2'd1;
        inval = 1'b0;
        if (cc == 2'b11) begin
            inval = 1'b1;
        end else if (cc == 2'b01) begin
            len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
        end else begin
            case (bbb)
                3'b011, 3'b111:         len = 2'd3;
                3'b001, 3'b100, 3'b101: len = 2'd2;
                // Row 000 mixes immediates (a>=4), JSR abs and implied BRK/RTI/RTS.
                3'b000: begin
                    if (opcode[7])            len = 2'd2;
                    else if (opcode == 8'h20) len = 2'd3;
                    else                      len = 2'd1;
                end
                default:                len = 2'd1;
            endcase
        end
    end

endmodule

// File: rtl/cpu_fetch.sv
// 6502 instruction fetch stage: owns the PC and assembles opcode + operands into one
// instruction per valid/ready handshake. Define FETCH_RESET_VECTOR_EN to load PC from the reset vector.
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0200,
    parameter logic [15:0] VECTOR_ADDR = DEFAULT_VECTOR_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [7:0]  ins_ir,
    output logic [7:0]  ins_op_lo,
    output logic [7:0]  ins_op_hi,
    output logic [1:0]  ins_len,
    output logic        ins_inval,
    output logic [15:0] ins_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

`ifdef FETCH_RESET_VECTOR_EN
    localparam fetch_state_t START_STATE = FETCH_VEC_LO;
    localparam logic [15:0]  START_PC    = 16'h0000;
`else
    localparam fetch_state_t START_STATE = FETCH_OPC;
    localparam logic [15:0]  START_PC    = RESET_PC;
`endif

    fetch_state_t state, state_nxt;
    logic [15:0]  pc;
    logic [1:0]   dec_len;
    logic         dec_inval;

    cpu_ins_length u_len (
        .opcode (mem_data),
        .len    (dec_len),
        .inval  (dec_inval)
    );

    // Reset masks the request and valid combinationally so an in-flight read is abandoned.
    assign mem_rd    = (state != FETCH_HOLD) && !rst;
    assign ins_valid = (state == FETCH_HOLD) && !rst;

    always_comb begin
        case (state)
            FETCH_VEC_LO: mem_addr = VECTOR_ADDR;
            FETCH_VEC_HI: mem_addr = VECTOR_ADDR + 16'd1;
            default:      mem_addr = pc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = FETCH_OPC;
        end else begin
            case (state)
`ifdef FETCH_RESET_VECTOR_EN
                FETCH_VEC_LO: if (mem_ack) state_nxt = FETCH_VEC_HI;
                FETCH_VEC_HI: if (mem_ack) state_nxt = FETCH_OPC;
`endif
                FETCH_OPC:  if (mem_ack) state_nxt = (dec_len == 2'd1) ? FETCH_HOLD : FETCH_OP1;
                FETCH_OP1:  if (mem_ack) state_nxt = (ins_len == 2'd2) ? FETCH_HOLD : FETCH_OP2;
                FETCH_OP2:  if (mem_ack) state_nxt = FETCH_HOLD;
                FETCH_HOLD: if (ins_ready) state_nxt = FETCH_OPC;
                default:    state_nxt = FETCH_OPC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= START_STATE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= START_PC;
            ins_ir    <= 8'h00;
            ins_op_lo <= 8'h00;
            ins_op_hi <= 8'h00;
            ins_len   <= 2'd0;
            ins_inval <= 1'b0;
            ins_pc    <= 16'h0000;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (mem_ack) begin
            case (state)
`ifdef FETCH_RESET_VECTOR_EN
                FETCH_VEC_LO: pc[7:0]  <= mem_data;
                FETCH_VEC_HI: pc[15:8] <= mem_data;
`endif
                FETCH_OPC: begin
                    ins_ir    <= mem_data;
                    ins_pc    <= pc;
                    ins_op_lo <= 8'h00;
                    ins_op_hi <= 8'h00;
                    ins_len   <= dec_len;
                    ins_inval <= dec_inval;
                    pc        <= pc + 16'd1;
                end
                FETCH_OP1: begin
                    ins_op_lo <= mem_data;
                    pc        <= pc + 16'd1;
                end
                FETCH_OP2: begin
                    ins_op_hi <= mem_data;
                    pc        <= pc + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed scenarios followed by randomized bus
// wait states, back-pressure, redirects and resets against an instruction-stream model.
module tb_cpu_fetch;

    localparam logic [15:0] VEC = 16'hFFFC;
`ifdef FETCH_RESET_VECTOR_EN
    localparam int FIRST_LAT = 3;
`else
    localparam int FIRST_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [7:0]  ins_ir, ins_op_lo, ins_op_hi;
    logic [1:0]  ins_len;
    logic        ins_inval;
    logic [15:0] ins_pc;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;

    cpu_fetch dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_data(mem_data), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .ins_ir(ins_ir), .ins_op_lo(ins_op_lo),
        .ins_op_hi(ins_op_hi), .ins_len(ins_len), .ins_inval(ins_inval),
        .ins_pc(ins_pc), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [65536];

    int total = 0;
    int bad   = 0;
    int shown = 0;

    // Stimulus controls
    logic        rst_req = 1'b1;
    int          ack_mode = 1;      // 0 random, 1 always, 2 never
    int          ready_mode = 2;    // 0 random, 1 always, 2 never
    logic        rand_redir = 1'b0;
    logic        rand_rst = 1'b0;
    logic        redir_pending = 1'b0;
    logic [15:0] redir_target = 16'h0000;

    // Sampled outputs of the last cycle
    logic        s_valid, s_rd;
    logic [15:0] s_addr;

    // Instruction-stream model
    logic [15:0] m_pc;
    int          m_n, m_len, vec_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (shown < 40) begin
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
                shown++;
            end
        end
    endtask

    function automatic int ref_len(input logic [7:0] op);
        logic [7:0] m3_01, m3_x0, m2_x0;
        int b;
        m3_01 = 8'hC8;
        m3_x0 = 8'h88;
        m2_x0 = 8'h32;
        b = int'(op[4:2]);
        if (op[1:0] == 2'b11) return 1;
        if (op[0]) return m3_01[b] ? 3 : 2;
        if (b == 0) return (op == 8'h20) ? 3 : (op[7] ? 2 : 1);
        return m3_x0[b] ? 3 : (m2_x0[b] ? 2 : 1);
    endfunction

    function automatic void reset_model();
`ifdef FETCH_RESET_VECTOR_EN
        vec_left = 2;
        m_pc     = 16'h0000;
`else
        vec_left = 0;
        m_pc     = 16'h0200;
`endif
        m_n   = 0;
        m_len = 0;
    endfunction

    task automatic cycle();
        logic        complete, cur_rd, acc, xfer;
        logic [15:0] cur_addr, a1, a2;
        logic [7:0]  op;
        int          l;
        @(negedge clk);
        s_valid = ins_valid;
        s_rd    = mem_rd;
        s_addr  = mem_addr;
        if (rst) begin
            check("rst_rd", mem_rd, 1'b0);
            check("rst_valid", ins_valid, 1'b0);
        end else begin
            complete = (vec_left == 0) && (m_len != 0) && (m_n == m_len);
            check("valid", ins_valid, complete);
            check("rd", mem_rd, !complete);
            if (!complete) begin
                if (vec_left > 0) check("vec_addr", mem_addr, VEC + 16'(2 - vec_left));
                else              check("addr", mem_addr, m_pc + 16'(m_n));
            end else begin
                op = mem[m_pc];
                l  = ref_len(op);
                a1 = m_pc + 16'd1;
                a2 = m_pc + 16'd2;
                check("ir", ins_ir, op);
                check("pc", ins_pc, m_pc);
                check("len", ins_len, l);
                check("inval", ins_inval, op[1:0] == 2'b11);
                check("op_lo", ins_op_lo, (l >= 2) ? mem[a1] : 8'h00);
                check("op_hi", ins_op_hi, (l == 3) ? mem[a2] : 8'h00);
            end
        end
        // Drive the inputs for the coming edge
        rst = rst_req || (rand_rst && $urandom_range(0, 299) == 0);
        #1;
        cur_rd   = mem_rd;
        cur_addr = mem_addr;
        mem_ack  = cur_rd && (ack_mode == 1 || (ack_mode == 0 && $urandom_range(0, 99) < 70));
        mem_data = mem_ack ? mem[cur_addr] : 8'($urandom);
        ins_ready = (ready_mode == 1) || (ready_mode == 0 && $urandom_range(0, 99) < 60);
        if (redir_pending) begin
            redirect      = 1'b1;
            redirect_pc   = redir_target;
            redir_pending = 1'b0;
        end else if (rand_redir && $urandom_range(0, 99) < 3) begin
            redirect    = 1'b1;
            redirect_pc = 16'($urandom);
        end else begin
            redirect    = 1'b0;
            redirect_pc = 16'($urandom);
        end
        // Predict the effect of that edge
        xfer = cur_rd && mem_ack;
        acc  = ins_valid && ins_ready;
        if (rst) begin
            reset_model();
        end else if (redirect) begin
            m_pc     = redirect_pc;
            m_n      = 0;
            m_len    = 0;
            vec_left = 0;
        end else if (xfer) begin
            if (vec_left == 2)      begin m_pc[7:0]  = mem_data; vec_left--; end
            else if (vec_left == 1) begin m_pc[15:8] = mem_data; vec_left--; end
            else begin
                if (m_n == 0) m_len = ref_len(mem[m_pc]);
                m_n++;
            end
        end else if (acc) begin
            m_pc  = m_pc + 16'(m_len);
            m_n   = 0;
            m_len = 0;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < 60);
        check("wait_valid", s_valid, 1'b1);
    endtask

    task automatic accept_one();
        ready_mode = 1;
        cycle();
        ready_mode = 2;
    endtask

    initial begin
        int          n;
        logic [7:0]  snap_ir, snap_lo;
        logic [15:0] snap_pc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0200] = 8'hEA;
        mem[16'h0201] = 8'hAD; mem[16'h0202] = 8'h34; mem[16'h0203] = 8'h12;
        mem[16'h0204] = 8'hA9; mem[16'h0205] = 8'h05;
        mem[16'h0206] = 8'h20; mem[16'h0207] = 8'h5A; mem[16'h0208] = 8'hC3;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h02;
        mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'hFF;
        reset_model();

        repeat (3) cycle();
        check("rst_ir", ins_ir, 8'h00);
        check("rst_op_lo", ins_op_lo, 8'h00);
        check("rst_op_hi", ins_op_hi, 8'h00);
        check("rst_len", ins_len, 2'd0);
        check("rst_inval", ins_inval, 1'b0);
        check("rst_pc", ins_pc, 16'h0000);

        // Release reset, bus always ready, consumer stalled
        rst_req = 1'b0;
        cycle();
        wait_valid(n);
        check("first_lat", n, FIRST_LAT);
        check("first_ir", ins_ir, 8'hEA);
        check("first_pc", ins_pc, 16'h0200);
        check("first_len", ins_len, 2'd1);

        snap_ir = ins_ir; snap_pc = ins_pc; snap_lo = ins_op_lo;
        repeat (5) begin
            cycle();
            check("hold_rd", s_rd, 1'b0);
        end
        check("hold_ir", ins_ir, snap_ir);
        check("hold_pc", ins_pc, snap_pc);
        check("hold_lo", ins_op_lo, snap_lo);

        accept_one();
        cycle();
        check("next_rd", s_rd, 1'b1);
        check("next_addr", s_addr, 16'h0201);
        wait_valid(n);
        check("abs_lat", n, 3);
        check("abs_len", ins_len, 2'd3);
        check("abs_lo", ins_op_lo, 8'h34);
        check("abs_hi", ins_op_hi, 8'h12);

        accept_one();
        cycle();
        check("after_abs_addr", s_addr, 16'h0204);
        wait_valid(n);
        check("imm_lat", n, 2);
        check("imm_len", ins_len, 2'd2);
        check("imm_lo", ins_op_lo, 8'h05);
        check("imm_hi", ins_op_hi, 8'h00);

        // Wait states on OP1, then redirect with a simultaneous ack on OP2
        accept_one();
        cycle();
        ack_mode = 2;
        repeat (3) begin
            cycle();
            check("ws_addr", s_addr, 16'h0207);
            check("ws_rd", s_rd, 1'b1);
        end
        ack_mode = 1;
        cycle();
        redir_target  = 16'h8000;
        redir_pending = 1'b1;
        cycle();
        check("op2_addr", s_addr, 16'h0208);
        cycle();
        check("redir_addr", s_addr, 16'h8000);
        check("redir_valid", s_valid, 1'b0);
        check("redir_lo", ins_op_lo, 8'h5A);
        check("redir_hi", ins_op_hi, 8'h00);
        wait_valid(n);
        check("redir_pc", ins_pc, 16'h8000);

        // Address wrap at the top of memory
        redir_target  = 16'hFFFF;
        redir_pending = 1'b1;
        cycle();
        wait_valid(n);
        check("wrap_ir", ins_ir, 8'hFF);
        check("wrap_inval", ins_inval, 1'b1);
        check("wrap_len", ins_len, 2'd1);
        check("wrap_pc", ins_pc, 16'hFFFF);
        accept_one();
        cycle();
        check("wrap_next", s_addr, 16'h0000);

        redir_target  = 16'hFFFE;
        redir_pending = 1'b1;
        cycle();
        wait_valid(n);
        check("wrap2_len", ins_len, 2'd2);
        check("wrap2_lo", ins_op_lo, 8'hFF);
        check("wrap2_pc", ins_pc, 16'hFFFE);
        accept_one();
        cycle();
        check("wrap2_next", s_addr, 16'h0000);

        // Randomized traffic
        ack_mode   = 0;
        ready_mode = 0;
        rand_redir = 1'b1;
        rand_rst   = 1'b1;
        repeat (4000) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
